// File: rtl/osc_readout_uart_if.sv
// Read-side bus between the oscillator bank's sample memory and the UART readout block.
// master = readout block (drives ADDRESS, TX, status), slave = bank/host side.
interface osc_readout_uart_if #(
    parameter int ADD_WIDTH  = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic                  bank_ready;
    logic [ADD_WIDTH-1:0]  address;
    logic [DATA_WIDTH-1:0] data;
    logic                  tx;
    logic                  busy;
    logic                  done;
    logic                  aborted;

    modport master (
        input  start, bank_ready, data,
        output address, tx, busy, done, aborted
    );

    modport slave (
        output start, bank_ready, data,
        input  address, tx, busy, done, aborted
    );
endinterface

// File: rtl/osc_readout_uart.sv
// Walks the bank's sample memory and streams each 16-bit sample as two 8N1 bytes, MSB first.
// Optional OSC_READOUT_CHECKSUM_EN appends a 16-bit running sum as two extra bytes. READ_LATENCY >= 1.
module osc_readout_uart #(
    parameter int ADD_WIDTH    = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_SAMPLES  = 16384,
    parameter int CLKS_PER_BIT = 868,
    parameter int READ_LATENCY = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    osc_readout_uart_if.master rd_if
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
    localparam logic [ADD_WIDTH-1:0] ADDR_LAST = ADD_WIDTH'(NUM_SAMPLES - 1);
    localparam logic [3:0]           STOP_IDX  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETADDR,
        S_WAIT,
        S_SEND_HI,
        S_SEND_LO,
`ifdef OSC_READOUT_CHECKSUM_EN
        S_SUM_HI,
        S_SUM_LO,
`endif
        S_FINISH
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADD_WIDTH-1:0]  r_addr;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_aborted;
    logic                  r_abort_req;
    logic [7:0]            r_sample_lo;
    logic [8:0]            r_shift;
    logic [3:0]            r_bit_idx;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [WAIT_W-1:0]     r_wait_cnt;
`ifdef OSC_READOUT_CHECKSUM_EN
    logic [15:0]           r_sum;
`endif

    logic                  w_accept;
    logic                  w_capture;
    logic                  w_load_frame;
    logic [7:0]            w_frame_byte;
    logic                  w_addr_inc;
    logic                  w_end_done;
    logic                  w_end_abort;
    logic                  w_sending;
    logic                  w_frame_done;
    logic                  w_abort_pend;

    assign rd_if.address = r_addr;
    assign rd_if.tx      = r_tx;
    assign rd_if.busy    = r_busy;
    assign rd_if.done    = r_done;
    assign rd_if.aborted = r_aborted;

`ifdef OSC_READOUT_CHECKSUM_EN
    assign w_sending = (r_state == S_SEND_HI) || (r_state == S_SEND_LO) ||
                       (r_state == S_SUM_HI)  || (r_state == S_SUM_LO);
`else
    assign w_sending = (r_state == S_SEND_HI) || (r_state == S_SEND_LO);
`endif

    assign w_frame_done = w_sending && (r_bit_cnt == BIT_LAST) && (r_bit_idx == STOP_IDX);
    // A drop seen in the current cycle counts as well as one latched earlier in the dump.
    assign w_abort_pend = r_abort_req || !rd_if.bank_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every combinational output is defaulted first so no branch can infer a latch.
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_load_frame = 1'b0;
        w_frame_byte = 8'h00;
        w_addr_inc   = 1'b0;
        w_end_done   = 1'b0;
        w_end_abort  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (rd_if.start && rd_if.bank_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETADDR;
                end
            end
            S_SETADDR: begin
                if (w_abort_pend) begin
                    w_end_abort = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_abort_pend) begin
                    w_end_abort = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_capture    = 1'b1;
                    w_load_frame = 1'b1;
                    w_frame_byte = rd_if.data[15:8];
                    w_state_nxt  = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (w_frame_done) begin
                    if (w_abort_pend) begin
                        w_end_abort = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_load_frame = 1'b1;
                        w_frame_byte = r_sample_lo;
                        w_state_nxt  = S_SEND_LO;
                    end
                end
            end
            S_SEND_LO: begin
                if (w_frame_done) begin
                    if (w_abort_pend) begin
                        w_end_abort = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_addr == ADDR_LAST) begin
`ifdef OSC_READOUT_CHECKSUM_EN
                        w_load_frame = 1'b1;
                        w_frame_byte = r_sum[15:8];
                        w_state_nxt  = S_SUM_HI;
`else
                        w_state_nxt  = S_FINISH;
`endif
                    end else begin
                        w_addr_inc  = 1'b1;
                        w_state_nxt = S_SETADDR;
                    end
                end
            end
`ifdef OSC_READOUT_CHECKSUM_EN
            S_SUM_HI: begin
                if (w_frame_done) begin
                    if (w_abort_pend) begin
                        w_end_abort = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_load_frame = 1'b1;
                        w_frame_byte = r_sum[7:0];
                        w_state_nxt  = S_SUM_LO;
                    end
                end
            end
            S_SUM_LO: begin
                if (w_frame_done) begin
                    if (w_abort_pend) begin
                        w_end_abort = 1'b1;
                    end
                    w_state_nxt = w_abort_pend ? S_IDLE : S_FINISH;
                end
            end
`endif
            S_FINISH: begin
                w_end_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status, address and sample capture: the address is the sample counter itself.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_addr      <= '0;
            r_abort_req <= 1'b0;
            r_wait_cnt  <= '0;
            r_sample_lo <= 8'h00;
        end else begin
            r_done    <= w_end_done;
            r_aborted <= w_end_abort;

            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (w_end_done || w_end_abort) begin
                r_busy <= 1'b0;
            end

            if (w_accept || w_end_done || w_end_abort) begin
                r_addr <= '0;
            end else if (w_addr_inc) begin
                r_addr <= r_addr + 1'b1;
            end

            if (w_accept || w_end_done || w_end_abort) begin
                r_abort_req <= 1'b0;
            end else if (r_busy && !rd_if.bank_ready) begin
                r_abort_req <= 1'b1;
            end

            if (r_state == S_SETADDR) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_capture) begin
                r_sample_lo <= rd_if.data[7:0];
            end
        end
    end

`ifdef OSC_READOUT_CHECKSUM_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum <= 16'h0000;
        end else if (w_accept) begin
            r_sum <= 16'h0000;
        end else if (w_capture) begin
            r_sum <= r_sum + rd_if.data;
        end
    end
`endif

    // UART shifter: start bit goes out on the load edge, stop bit is the 1 shifted in behind the data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx      <= 1'b1;
            r_shift   <= 9'h1FF;
            r_bit_idx <= 4'd0;
            r_bit_cnt <= '0;
        end else if (w_load_frame) begin
            r_tx      <= 1'b0;
            r_shift   <= {1'b1, w_frame_byte};
            r_bit_idx <= 4'd0;
            r_bit_cnt <= '0;
        end else if (w_sending) begin
            if (r_bit_cnt == BIT_LAST) begin
                r_bit_cnt <= '0;
                if (r_bit_idx == STOP_IDX) begin
                    r_tx <= 1'b1;
                end else begin
                    r_tx      <= r_shift[0];
                    r_shift   <= {1'b1, r_shift[8:1]};
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end else begin
            r_tx <= 1'b1;
        end
    end

endmodule

// File: tb/tb_osc_readout_uart.sv
// Bench for osc_readout_uart: table-driven and randomized dumps checked against a byte-stream model,
// plus hand-written reset-mid-frame and START-at-FINISH sequences.
module tb_osc_readout_uart;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int NS    = 4;
    localparam int CPB   = 4;
    localparam int RL    = 2;
    localparam int FRAME = 10 * CPB;
`ifdef OSC_READOUT_CHECKSUM_EN
    localparam int NB_FULL = 2 * NS + 2;
    localparam int EXTRA   = 20 * CPB;
`else
    localparam int NB_FULL = 2 * NS;
    localparam int EXTRA   = 0;
`endif
    localparam int DUMP_CYC = NS * (20 * CPB + RL + 1) + 2 + EXTRA;

    typedef struct {
        logic        ready;
        int          abort_byte;
        logic        retrig;
        logic        start_at_finish;
        logic [15:0] base;
        logic        exp_done;
        logic        exp_aborted;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    osc_readout_uart_if #(.ADD_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    osc_readout_uart #(
        .ADD_WIDTH   (AW),
        .DATA_WIDTH  (DW),
        .NUM_SAMPLES (NS),
        .CLKS_PER_BIT(CPB),
        .READ_LATENCY(RL)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .rd_if(bus.master)
    );

    // Bank model: DATA = base + ADDRESS, two register stages behind ADDRESS.
    logic [15:0] bank_base = 16'h1200;
    logic [15:0] bank_d1;
    always @(posedge clk) begin
        bank_d1  <= bank_base + bus.address;
        bus.data <= bank_d1;
    end

    // Line monitor, sampled 1 time unit after each rising edge.
    int         cyc = 0;
    logic [7:0] rx_q[$];
    int         fstart_q[$];
    int         fstarted = 0;
    int         mon_err = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         abort_cnt = 0;
    logic       in_frame = 1'b0;
    int         fpos = 0;
    logic       samp[FRAME];

    always @(posedge clk) begin
        logic [7:0] byte_v;
        logic       ok;
        #1;
        cyc++;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.aborted) abort_cnt++;
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && bus.tx == 1'b0) begin
                in_frame = 1'b1;
                fpos     = 0;
                fstart_q.push_back(cyc);
                fstarted++;
            end
            if (in_frame) begin
                samp[fpos] = bus.tx;
                fpos++;
                if (fpos == FRAME) begin
                    in_frame = 1'b0;
                    ok       = 1'b1;
                    byte_v   = 8'h00;
                    for (int b = 0; b < 10; b++)
                        for (int k = 1; k < CPB; k++)
                            if (samp[b*CPB+k] != samp[b*CPB]) ok = 1'b0;
                    if (samp[0] != 1'b0 || samp[9*CPB] != 1'b1) ok = 1'b0;
                    for (int b = 0; b < 8; b++) byte_v[b] = samp[(b+1)*CPB];
                    rx_q.push_back(byte_v);
                    if (!ok) mon_err++;
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference byte stream: samples as hi/lo bytes, optional sum, truncated after the aborted frame.
    logic [7:0] exp_q[$];
    task automatic build_model(input logic ready, input logic [15:0] base, input int abort_byte);
        logic [15:0] s;
        logic [15:0] sum;
        exp_q.delete();
        sum = 16'h0000;
        if (ready) begin
            for (int k = 0; k < NS; k++) begin
                s = base + 16'(k);
                exp_q.push_back(s[15:8]);
                exp_q.push_back(s[7:0]);
                sum = sum + s;
            end
`ifdef OSC_READOUT_CHECKSUM_EN
            exp_q.push_back(sum[15:8]);
            exp_q.push_back(sum[7:0]);
`endif
            if (abort_byte >= 0)
                while (exp_q.size() > abort_byte + 1) void'(exp_q.pop_back());
        end
    endtask

    task automatic run_dump(input vec_t v, input string tag, output int q0);
        int f0, d0, a0, e0, c0, waited, budget, bad_gap, gap;
        q0 = rx_q.size();
        f0 = fstarted;
        d0 = done_cnt;
        a0 = abort_cnt;
        e0 = mon_err;
        build_model(v.ready, v.base, v.abort_byte);
        bank_base = v.base;
        @(negedge clk);
        bus.bank_ready = v.ready;
        bus.start      = 1'b1;
        c0             = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        waited    = 0;
        budget    = v.ready ? DUMP_CYC + 50 : 60;
        while (done_cnt == d0 && abort_cnt == a0 && waited < budget) begin
            if (v.abort_byte >= 0 && fstarted >= f0 + v.abort_byte + 1) bus.bank_ready = 1'b0;
            bus.start = (v.retrig && waited == 20) ||
                        (v.start_at_finish && cyc == c0 + DUMP_CYC - 1);
            @(negedge clk);
            waited++;
        end
        bus.start = 1'b0;
        check({tag, " end_seen"}, 32'(done_cnt != d0 || abort_cnt != a0),
              32'(v.exp_done || v.exp_aborted));
        repeat (12) @(negedge clk);
        check({tag, " nbytes"}, 32'(rx_q.size() - q0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (q0 + i < rx_q.size())
                check($sformatf("%s byte%0d", tag, i), 32'(rx_q[q0+i]), 32'(exp_q[i]));
        check({tag, " done_pulses"}, 32'(done_cnt - d0), 32'(v.exp_done));
        check({tag, " aborted_pulses"}, 32'(abort_cnt - a0), 32'(v.exp_aborted));
        check({tag, " framing"}, 32'(mon_err - e0), 32'd0);
        check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, " tx_after"}, 32'(bus.tx), 32'd1);
        check({tag, " addr_after"}, 32'(bus.address), 32'd0);
        if (v.exp_done) begin
            check({tag, " start_to_done"}, 32'(done_cyc - c0), 32'(DUMP_CYC));
            bad_gap = 0;
            for (int i = f0; i + 1 < fstarted; i++) begin
                gap = ((i - f0) % 2 == 1 && (i - f0) + 1 < 2 * NS) ? FRAME + RL + 1 : FRAME;
                if (fstart_q[i+1] - fstart_q[i] != gap) bad_gap++;
            end
            check({tag, " frame_spacing"}, 32'(bad_gap), 32'd0);
        end
        bus.bank_ready = 1'b1;
    endtask

    vec_t vecs[6];
    int   sidx[6];

    initial begin
        int   q0, f0, waited, mism, ab;
        vec_t rv;

        vecs[0] = '{1'b1, -1, 1'b1, 1'b0, 16'h1200, 1'b1, 1'b0};
        vecs[1] = '{1'b0, -1, 1'b0, 1'b0, 16'h1200, 1'b0, 1'b0};
        vecs[2] = '{1'b1,  3, 1'b0, 1'b0, 16'h1200, 1'b0, 1'b1};
        vecs[3] = '{1'b1,  0, 1'b0, 1'b0, 16'h1200, 1'b0, 1'b1};
        vecs[4] = '{1'b1, -1, 1'b0, 1'b1, 16'h1200, 1'b1, 1'b0};
        vecs[5] = '{1'b1, -1, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.bank_ready = 1'b1;
        #2;
        check("reset tx", 32'(bus.tx), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset aborted", 32'(bus.aborted), 32'd0);
        check("reset address", 32'(bus.address), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_dump(vecs[i], $sformatf("vec%0d", i), q0);
            sidx[i] = q0;
        end

        // A later START after a retriggered dump reproduces the same stream.
        mism = 0;
        for (int i = 0; i < NB_FULL; i++)
            if (sidx[4] + i >= rx_q.size() || rx_q[sidx[0]+i] != rx_q[sidx[4]+i]) mism++;
        check("retrigger identical stream", 32'(mism), 32'd0);

        // Reset during the start bit of sample 1's high byte.
        bank_base = 16'h1200;
        f0        = fstarted;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waited    = 0;
        while (fstarted < f0 + 3 && waited < DUMP_CYC) begin
            @(negedge clk);
            waited++;
        end
        check("midframe tx before reset", 32'(bus.tx), 32'd0);
        check("midframe addr before reset", 32'(bus.address), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midframe reset tx", 32'(bus.tx), 32'd1);
        check("midframe reset busy", 32'(bus.busy), 32'd0);
        check("midframe reset address", 32'(bus.address), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        f0  = fstarted;
        repeat (100) @(negedge clk);
        check("no resume frames", 32'(fstarted - f0), 32'd0);
        check("no resume busy", 32'(bus.busy), 32'd0);

        for (int r = 0; r < 6; r++) begin
            ab = int'($urandom_range(0, NB_FULL)) - 1;
            if ($urandom_range(0, 2) == 0) ab = -1;
            rv = '{1'b1, ab, 1'($urandom_range(0, 1)), 1'b0, 16'($urandom),
                   1'(ab < 0), 1'(ab >= 0)};
            repeat ($urandom_range(0, 7)) @(negedge clk);
            run_dump(rv, $sformatf("rnd%0d", r), q0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/osc_readout_uart.md
Name: osc_readout_uart

Overview:
Downstream consumer of the oscillator bank's sample memory.
- Once a recording has finished and the bank is in read mode, a START request makes the block walk ADDRESS from 0 to NUM_SAMPLES-1.
- For each address it captures the returned DATA word after the fixed memory read latency.
- Each sample goes out over an 8N1 UART TX line as two bytes, MSB first.
- It is the only path for getting recorded RO counts off the FPGA to the host.

Parameters:
- ADD_WIDTH, 16, width of the ADDRESS output.
- DATA_WIDTH, 16, sample width. Fixed at 16; two bytes per sample.
- NUM_SAMPLES, 16384, number of addresses read per dump. Range 1..2^ADD_WIDTH.
- CLKS_PER_BIT, 868, CLOCK cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- READ_LATENCY, 2, cycles from ADDRESS change to valid DATA.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle dump request.
- BANK_READY  in  1  high while the bank is idle and in read mode (recording finished).
- ADDRESS  out  ADD_WIDTH  read address to the bank.
- DATA  in  DATA_WIDTH  read data from the bank.
- TX  out  1  UART serial output; idle high.
- BUSY  out  1  high from START acceptance until the last stop bit ends.
- DONE  out  1  one-cycle pulse when a dump completes normally.
- ABORTED  out  1  one-cycle pulse when a dump is cut short because BANK_READY dropped.

Behaviour:
- Reset values (asynchronous): TX=1, ADDRESS=0, BUSY=0, DONE=0, ABORTED=0, state IDLE, all counters 0.
- States: IDLE -> SETADDR -> WAIT -> SEND_HI -> SEND_LO -> (SETADDR | FINISH) -> IDLE.
- IDLE:
  - START accepted only if BANK_READY=1; otherwise ignored.
  - On acceptance: BUSY=1 on the next edge, address counter=0, go to SETADDR.
  - START while BUSY is ignored.
- SETADDR: drive ADDRESS=counter for one cycle, then WAIT.
- WAIT:
  - Hold ADDRESS for READ_LATENCY cycles.
  - On the last cycle, register DATA into the sample register. ADDRESS stays stable until the next SETADDR.
- UART byte frame:
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
  - No idle gap between consecutive frames.
- SEND_HI sends sample[15:8]; SEND_LO sends sample[7:0].
- After SEND_LO:
  - If counter = NUM_SAMPLES-1, go to FINISH.
  - Otherwise increment counter and go to SETADDR. The SETADDR/WAIT cycles add READ_LATENCY+1 idle-high cycles between samples.
- Counter does not wrap. NUM_SAMPLES = 2^ADD_WIDTH ends at the all-ones address.
- FINISH: DONE=1 for one cycle, BUSY=0, ADDRESS returns to 0, go to IDLE.
- Abort on BANK_READY low while BUSY:
  - The current frame completes, including its stop bit. No partial frames, ever.
  - Then ABORTED pulses one cycle, BUSY=0, ADDRESS=0, go to IDLE. DONE is not pulsed.
- Simultaneous START and end of FINISH: START is ignored (BUSY still high that cycle).
- RESET mid-frame: TX forced high immediately. No resumption; a new START is required.
- Total dump time, normal case: NUM_SAMPLES*(20*CLKS_PER_BIT + READ_LATENCY + 1) + 2 cycles from START to DONE.

Optional Feature:
- Macro OSC_READOUT_CHECKSUM_EN.
- Defined:
  - The block keeps a 16-bit running sum (mod 2^16) of all sent samples, cleared at START acceptance.
  - After the last sample it sends the sum as two more frames, MSB first, then goes to FINISH.
  - The sum is not sent on abort.
  - Timing adds 20*CLKS_PER_BIT cycles.
- Not defined: no accumulator logic; FINISH follows the last sample directly.

Test Plan:
All scenarios use CLKS_PER_BIT=4, NUM_SAMPLES=4, READ_LATENCY=2, and a bank model returning DATA = 0x1200+ADDRESS after 2 cycles.
- Reset check: assert RESET mid-frame -> TX=1, BUSY=0, ADDRESS=0 in the same cycle, without waiting for a clock edge.
- Normal dump: START with BANK_READY=1 -> TX bytes 12 00 12 01 12 02 12 03; each bit 4 cycles; DONE single pulse; BUSY low afterwards; cycle count START->DONE = 4*(80+3)+2.
- START with BANK_READY=0 -> no activity, TX stays 1, BUSY stays 0.
- Abort: drop BANK_READY during the low byte of sample 1 -> frame 0x01 completes with its stop bit, ABORTED pulses, no DONE, TX idle.
- Re-trigger: START asserted while BUSY -> ignored; a later START after DONE produces an identical byte stream.
- With OSC_READOUT_CHECKSUM_EN: the normal dump is followed by bytes 48 06 (0x4806), then DONE.
